// File: rtl/ram_sdp_clr_pkg.sv
// Shared types and helpers for the clearable simple-dual-port RAM.
package ram_pkg;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam int BYTE_W     = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int be_count(input int data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic bit rd_lat_legal(input int rd_lat);
    return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
  endfunction

  function automatic bit data_w_legal(input int data_w);
    return (data_w > 0) && ((data_w % BYTE_W) == 0);
  endfunction

endpackage

// File: rtl/ram_sdp_clr_if.sv
// Access bus of ram_sdp_clr: write port, read port and clear control.
interface ram_sdp_clr_if
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  localparam int BE_W = be_count(DATA_W);

  logic              clr_start;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              req_drop;

  modport master (
    output clr_start, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  busy, rd_data, rd_valid, req_drop
  );

  modport slave (
    input  clr_start, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output busy, rd_data, rd_valid, req_drop
  );

endinterface

// File: rtl/ram_sdp_clr_core.sv
// Block-RAM storage: byte-enabled write port, registered read port, collision mux.
module ram_sdp_core
  import ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int WR_FIRST = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [be_count(DATA_W)-1:0] wbe,
  input  logic                      re,
  input  logic [ADDR_W-1:0]         raddr,
  output logic [DATA_W-1:0]         rdata
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = be_count(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wbe[b]) mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

  generate
    if (WR_FIRST != 0) begin : g_wr_first
      // Forward only the bytes being written this cycle; others come from the array.
      logic [DATA_W-1:0] merged;
      for (genvar gi = 0; gi < BE_W; gi++) begin : g_byte
        assign merged[gi*BYTE_W +: BYTE_W] = (we && wbe[gi] && (waddr == raddr))
                                           ? wdata[gi*BYTE_W +: BYTE_W]
                                           : mem[raddr][gi*BYTE_W +: BYTE_W];
      end
      assign rd_word = merged;
    end else begin : g_rd_first
      assign rd_word = mem[raddr];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)     rdata_reg <= '0;
    else if (re) rdata_reg <= rd_word;
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with a sweeping clear engine, busy arbitration and 1/2-cycle reads.
module ram_sdp_clr
  import ram_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 4,
  parameter int              RD_LAT   = 1,
  parameter int              WR_FIRST = 0,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  ram_sdp_clr_if.slave  bus
);
  localparam int BE_W = be_count(DATA_W);

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("ram_sdp_clr: DATA_W must be a positive multiple of 8");
  end
  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("ram_sdp_clr: RD_LAT must be 1 or 2");
  end

  state_t            state_reg;
  logic [ADDR_W-1:0] clr_addr_reg;
  logic              busy_reg;
  logic              rd_v1_reg;
  logic              req_drop_reg;

  logic              wr_acc, rd_acc, clearing;
  logic              core_we;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata;
  logic [BE_W-1:0]   core_wbe;
  logic [DATA_W-1:0] core_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= '0;
      busy_reg     <= 1'b1;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_addr_reg <= clr_addr_reg + 1'b1;
          if (clr_addr_reg == '1) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.clr_start) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= '0;
            busy_reg     <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_CLEAR;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

  // The clear engine owns the write port whenever it is sweeping.
  assign clearing   = (state_reg == ST_CLEAR);
  assign wr_acc     = bus.wr_en & ~busy_reg & ~rst;
  assign rd_acc     = bus.rd_en & ~busy_reg & ~rst;
  assign core_we    = ~rst & (clearing | wr_acc);
  assign core_waddr = clearing ? clr_addr_reg : bus.wr_addr;
  assign core_wdata = clearing ? CLR_VAL : bus.wr_data;
  assign core_wbe   = clearing ? {BE_W{1'b1}} : bus.wr_be;

  ram_sdp_core #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .WR_FIRST (WR_FIRST)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (core_we),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .wbe   (core_wbe),
    .re    (rd_acc),
    .raddr (bus.rd_addr),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1_reg    <= 1'b0;
      req_drop_reg <= 1'b0;
    end else begin
      rd_v1_reg    <= rd_acc;
      req_drop_reg <= busy_reg & (bus.wr_en | bus.rd_en);
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] rd_data_reg;
      logic              rd_valid_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_v1_reg;
          if (rd_v1_reg) rd_data_reg <= core_rdata;
        end
      end
      assign bus.rd_data  = rd_data_reg;
      assign bus.rd_valid = rd_valid_reg;
    end else begin : g_lat1
      assign bus.rd_data  = core_rdata;
      assign bus.rd_valid = rd_v1_reg;
    end
  endgenerate

  assign bus.busy     = busy_reg;
  assign bus.req_drop = req_drop_reg;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Directed bench: three ram_sdp_clr variants driven by one shared stimulus stream.
module tb_ram_sdp_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_start = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  int checks = 0;
  int errors = 0;
  int cnt;
  int guard;

  always #5 clk = ~clk;

  // a: defaults (8-bit, latency 1, old-data collisions, clear to 0)
  // b: 16-bit, latency 1, new-data collisions, clear to 0
  // c: 16-bit, latency 2, old-data collisions, clear to 0xC1C1
  ram_sdp_clr_if #(.DATA_W(8),  .ADDR_W(4)) ia ();
  ram_sdp_clr_if #(.DATA_W(16), .ADDR_W(4)) ib ();
  ram_sdp_clr_if #(.DATA_W(16), .ADDR_W(4)) ic ();

  assign ia.clr_start = clr_start;
  assign ia.wr_en     = wr_en;
  assign ia.wr_addr   = wr_addr;
  assign ia.wr_data   = wr_data[7:0];
  assign ia.wr_be     = wr_be[0:0];
  assign ia.rd_en     = rd_en;
  assign ia.rd_addr   = rd_addr;

  assign ib.clr_start = clr_start;
  assign ib.wr_en     = wr_en;
  assign ib.wr_addr   = wr_addr;
  assign ib.wr_data   = wr_data;
  assign ib.wr_be     = wr_be;
  assign ib.rd_en     = rd_en;
  assign ib.rd_addr   = rd_addr;

  assign ic.clr_start = clr_start;
  assign ic.wr_en     = wr_en;
  assign ic.wr_addr   = wr_addr;
  assign ic.wr_data   = wr_data;
  assign ic.wr_be     = wr_be;
  assign ic.rd_en     = rd_en;
  assign ic.rd_addr   = rd_addr;

  ram_sdp_clr dut_a (.clk(clk), .rst(rst), .bus(ia));

  ram_sdp_clr #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .WR_FIRST(1), .CLR_VAL(16'h0000))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  ram_sdp_clr #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .WR_FIRST(0), .CLR_VAL(16'hC1C1))
    dut_c (.clk(clk), .rst(rst), .bus(ic));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-14s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  // Sweep all 16 addresses: a must read 0; c (two cycles) must read exp_c.
  task automatic read_sweep(input logic [15:0] exp_c);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      tick();
      chk("sweep_a_vld", 32'(ia.rd_valid), 32'd1);
      chk("sweep_a_dat", 32'(ia.rd_data), 32'h00);
      if (i > 0) begin
        chk("sweep_c_vld", 32'(ic.rd_valid), 32'd1);
        chk("sweep_c_dat", 32'(ic.rd_data), 32'(exp_c));
      end
    end
    rd_en = 1'b0;
    tick();
    chk("sweep_a_end", 32'(ia.rd_valid), 32'd0);
    chk("sweep_c_last", 32'(ic.rd_data), 32'(exp_c));
    tick();
    chk("sweep_c_end", 32'(ic.rd_valid), 32'd0);
  endtask

  initial begin
    // Reset: outputs cleared, accesses under reset are not reported as drops.
    rd_en = 1'b1;
    tick(); tick(); tick();
    chk("rst_busy", 32'(ia.busy), 32'd1);
    chk("rst_vld", 32'(ia.rd_valid), 32'd0);
    chk("rst_dat_a", 32'(ia.rd_data), 32'h00);
    chk("rst_dat_c", 32'(ic.rd_data), 32'h0000);
    chk("rst_drop", 32'(ia.req_drop), 32'd0);
    rd_en = 1'b0;
    rst = 1'b0;

    cnt = 0;
    guard = 0;
    while (ia.busy && guard < 40) begin
      tick(); cnt++; guard++;
    end
    chk("init_busy_len", 32'(cnt), 32'd16);
    chk("init_busy_b", 32'(ib.busy), 32'd0);
    chk("init_busy_c", 32'(ic.busy), 32'd0);
    read_sweep(16'hC1C1);

    // Byte enables: 0xBEEF full, then 0x1234 low byte only -> 0xBE34.
    wr(4'd3, 16'hBEEF, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    chk("be_b", 32'(ib.rd_data), 32'hBE34);
    chk("be_a", 32'(ia.rd_data), 32'h34);
    tick();
    chk("be_c_vld", 32'(ic.rd_valid), 32'd1);
    chk("be_c", 32'(ic.rd_data), 32'hBE34);
    wr(4'd3, 16'hFFFF, 2'b00);
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    chk("be0_b", 32'(ib.rd_data), 32'hBE34);
    chk("be0_a", 32'(ia.rd_data), 32'h34);

    // Collision at addr 5: old 0x11, write 0x22 with read the same cycle.
    wr(4'd5, 16'h0011, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0022; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    wr_en = 1'b0;
    chk("coll_old_a", 32'(ia.rd_data), 32'h11);
    chk("coll_new_b", 32'(ib.rd_data), 32'h0022);
    tick();
    rd_en = 1'b0;
    chk("coll_next_a", 32'(ia.rd_data), 32'h22);
    chk("coll_next_b", 32'(ib.rd_data), 32'h0022);
    chk("coll_old_c", 32'(ic.rd_data), 32'h0011);
    tick();
    chk("coll_next_c", 32'(ic.rd_data), 32'h0022);

    // Partial-byte collision at addr 6: 0xAAAA overwritten by 0x5555 on byte 0 only.
    wr(4'd6, 16'hAAAA, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h5555; wr_be = 2'b01;
    rd_en = 1'b1; rd_addr = 4'd6;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("pcoll_b", 32'(ib.rd_data), 32'hAA55);
    chk("pcoll_a", 32'(ia.rd_data), 32'hAA);
    tick();
    chk("pcoll_c", 32'(ic.rd_data), 32'hAAAA);

    // Latency-2 back-to-back reads of 0xA1, 0xA2, 0xA3.
    wr(4'd1, 16'h00A1, 2'b11);
    wr(4'd2, 16'h00A2, 2'b11);
    wr(4'd3, 16'h00A3, 2'b11);
    rd_en = 1'b1; rd_addr = 4'd1;
    tick();
    chk("lat2_vld0", 32'(ic.rd_valid), 32'd0);
    rd_addr = 4'd2;
    tick();
    chk("lat2_vld1", 32'(ic.rd_valid), 32'd1);
    chk("lat2_dat1", 32'(ic.rd_data), 32'h00A1);
    rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    chk("lat2_vld2", 32'(ic.rd_valid), 32'd1);
    chk("lat2_dat2", 32'(ic.rd_data), 32'h00A2);
    tick();
    chk("lat2_vld3", 32'(ic.rd_valid), 32'd1);
    chk("lat2_dat3", 32'(ic.rd_data), 32'h00A3);
    tick();
    chk("lat2_vld4", 32'(ic.rd_valid), 32'd0);
    chk("lat2_hold", 32'(ic.rd_data), 32'h00A3);

    // Clear with a simultaneous read, a dropped write, and an ignored clr_start.
    wr(4'd7, 16'h0077, 2'b11);
    clr_start = 1'b1; rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    cnt = 1;
    clr_start = 1'b0; rd_en = 1'b0;
    chk("clr_busy", 32'(ia.busy), 32'd1);
    chk("clr_rd_vld", 32'(ia.rd_valid), 32'd1);
    chk("clr_rd_dat", 32'(ia.rd_data), 32'h77);
    chk("clr_drop0", 32'(ia.req_drop), 32'd0);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00EE; wr_be = 2'b11;
    tick();
    if (ia.busy) cnt++;
    wr_en = 1'b0; clr_start = 1'b1;
    chk("drop_pulse", 32'(ia.req_drop), 32'd1);
    chk("drop_no_vld", 32'(ia.rd_valid), 32'd0);
    tick();
    if (ia.busy) cnt++;
    clr_start = 1'b0;
    chk("drop_end", 32'(ia.req_drop), 32'd0);
    guard = 0;
    while (ia.busy && guard < 40) begin
      tick(); guard++;
      if (ia.busy) cnt++;
    end
    chk("clr_busy_len", 32'(cnt), 32'd16);
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    rd_addr = 4'd3;
    chk("clr_a7", 32'(ia.rd_data), 32'h00);
    chk("clr_b7", 32'(ib.rd_data), 32'h0000);
    tick();
    rd_en = 1'b0;
    chk("clr_c7", 32'(ic.rd_data), 32'hC1C1);
    chk("clr_a3", 32'(ia.rd_data), 32'h00);

    // Reset when clr_addr reaches 9: sweep restarts, full 16 busy cycles.
    wr(4'd2, 16'h5555, 2'b11);
    wr(4'd14, 16'h6666, 2'b11);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(ia.busy), 32'd1);
    chk("mid_rst_vld", 32'(ia.rd_valid), 32'd0);
    rst = 1'b0;
    cnt = 0;
    guard = 0;
    while (ia.busy && guard < 40) begin
      tick(); cnt++; guard++;
    end
    chk("mid_busy_len", 32'(cnt), 32'd16);
    chk("mid_busy_c", 32'(ic.busy), 32'd0);
    read_sweep(16'hC1C1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
